// File: rtl/fetch_bundle_unpacker_if.sv
// rtl/fetch_bundle_unpacker_if.sv - fetch bundle in / instruction out handshake bundle
interface fetch_bundle_unpacker_if #(
  parameter int PC_WD = 32
);
  // Bundle side (I-cache / fetch stage to unpacker)
  logic             bundle_valid_i;
  logic             bundle_ready_o;
  logic [127:0]     bundle_i;
  logic [PC_WD-1:0] bundle_pc_i;
  logic [1:0]       bundle_start_i;

  // Instruction side (unpacker to decode)
  logic             inst_valid_o;
  logic             inst_ready_i;
  logic [31:0]      inst_o;
  logic [PC_WD-1:0] inst_pc_o;

  // Fetch stage and decode: drive bundles and ready, observe instructions
  modport master (
    output bundle_valid_i, bundle_i, bundle_pc_i, bundle_start_i, inst_ready_i,
    input  bundle_ready_o, inst_valid_o, inst_o, inst_pc_o
  );

  // Unpacker
  modport slave (
    input  bundle_valid_i, bundle_i, bundle_pc_i, bundle_start_i, inst_ready_i,
    output bundle_ready_o, inst_valid_o, inst_o, inst_pc_o
  );
endinterface

// File: rtl/fetch_bundle_unpacker.sv
// rtl/fetch_bundle_unpacker.sv - bundle FIFO emitting one instruction per cycle (optional FETCH_BUF_BYPASS_EN)
module fetch_bundle_unpacker #(
  parameter int DEPTH = 4,
  parameter int PC_WD = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  fetch_bundle_unpacker_if.slave     bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_WD = $clog2(DEPTH);
  localparam int CNT_WD = $clog2(DEPTH+1);

  // Entry storage: bundle, aligned PC, next slot to emit
  logic [127:0]       r_data [DEPTH];
  logic [PC_WD-1:0]   r_pc   [DEPTH];
  logic [1:0]         r_slot [DEPTH];

  logic [PTR_WD-1:0]  r_head;
  logic [PTR_WD-1:0]  r_tail;
  logic [CNT_WD-1:0]  r_count;

  logic [127:0]       w_head_data;
  logic [PC_WD-1:0]   w_head_pc;
  logic [1:0]         w_head_slot;
  logic [31:0]        w_fifo_inst;
  logic [PC_WD-1:0]   w_fifo_pc;
  logic               w_fifo_valid;
  logic               w_full;
  logic               w_push;
  logic               w_pop_fifo;
  logic               w_pop_last;
  logic               w_wr_en;
  logic [1:0]         w_wr_slot;
  logic [PC_WD-1:0]   w_bundle_pc_al;
  logic [3:0]         w_unused_pc_lo;

  assign w_head_data    = r_data[r_head];
  assign w_head_pc      = r_pc[r_head];
  assign w_head_slot    = r_slot[r_head];
  assign w_fifo_inst    = w_head_data[{w_head_slot, 5'b0} +: 32];
  assign w_fifo_pc      = w_head_pc + {{(PC_WD-4){1'b0}}, w_head_slot, 2'b00};

  assign w_fifo_valid   = (r_count != '0);
  // Ready depends only on registered occupancy; a same-cycle pop never raises it
  assign w_full         = (r_count >= CNT_WD'(DEPTH));
  assign w_push         = bus.bundle_valid_i && !w_full && !flush_i;
  assign w_pop_fifo     = w_fifo_valid && bus.inst_ready_i && !flush_i;
  assign w_pop_last     = w_pop_fifo && (w_head_slot == 2'd3);

  // Slot-0 PC is 16-byte aligned; the low nibble is deliberately dropped
  assign w_bundle_pc_al = {bus.bundle_pc_i[PC_WD-1:4], 4'b0000};
  assign w_unused_pc_lo = bus.bundle_pc_i[3:0];

`ifdef FETCH_BUF_BYPASS_EN
  logic w_bypass;
  logic w_byp_take;

  // Empty FIFO: the incoming bundle's first slot is presented straight to decode
  assign w_bypass   = !w_fifo_valid && w_push;
  assign w_byp_take = w_bypass && bus.inst_ready_i;
  // A consumed start slot advances the stored slot; a bundle holding only slot 3 is never stored
  assign w_wr_en    = w_push && !(w_byp_take && (bus.bundle_start_i == 2'd3));
  assign w_wr_slot  = w_byp_take ? (bus.bundle_start_i + 2'd1) : bus.bundle_start_i;

  assign bus.inst_valid_o = w_fifo_valid || w_bypass;
  assign bus.inst_o       = w_bypass ? bus.bundle_i[{bus.bundle_start_i, 5'b0} +: 32] : w_fifo_inst;
  assign bus.inst_pc_o    = w_bypass ? (w_bundle_pc_al + {{(PC_WD-4){1'b0}}, bus.bundle_start_i, 2'b00})
                                     : w_fifo_pc;
`else
  assign w_wr_en    = w_push;
  assign w_wr_slot  = bus.bundle_start_i;

  assign bus.inst_valid_o = w_fifo_valid;
  assign bus.inst_o       = w_fifo_inst;
  assign bus.inst_pc_o    = w_fifo_pc;
`endif

  assign bus.bundle_ready_o = !w_full;
  assign count_o            = r_count;

  // Pointers and occupancy; flush empties the FIFO and drops any same-cycle push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_tail <= r_tail + PTR_WD'(1);
      end
      if (w_pop_last) begin
        r_head <= r_head + PTR_WD'(1);
      end
      case ({w_wr_en, w_pop_last})
        2'b10:   r_count <= r_count + CNT_WD'(1);
        2'b01:   r_count <= r_count - CNT_WD'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry contents: write the tail on push, step the head slot on a non-final pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
        r_slot[i] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_data[r_tail] <= bus.bundle_i;
        r_pc[r_tail]   <= w_bundle_pc_al;
        r_slot[r_tail] <= w_wr_slot;
      end
      if (w_pop_fifo && !w_pop_last) begin
        r_slot[r_head] <= w_head_slot + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_bundle_unpacker.sv
// tb/tb_fetch_bundle_unpacker.sv - directed self-checking bench for fetch_bundle_unpacker
module tb_fetch_bundle_unpacker;

  logic       clk;
  logic       rst;
  logic       flush_i;
  logic [2:0] count_o;
  int         checks;
  int         failures;

  fetch_bundle_unpacker_if #(.PC_WD(32)) bus ();

  fetch_bundle_unpacker #(.DEPTH(4), .PC_WD(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .bus     (bus),
    .count_o (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] d, input logic [31:0] pc, input logic [1:0] st);
    bus.bundle_valid_i = v;
    bus.bundle_i       = d;
    bus.bundle_pc_i    = pc;
    bus.bundle_start_i = st;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush_i = 1'b0;
    bus.inst_ready_i = 1'b0;
    drive(1'b0, '0, '0, 2'd0);
    step();
    step();
    checks++; if (bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.inst_valid_o); end
    checks++; if (bus.inst_o !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", bus.inst_o); end
    checks++; if (bus.inst_pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.inst_pc_o); end
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (bus.bundle_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.bundle_ready_o); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [31:0] exp_inst [4];
    logic [31:0] exp_pc   [4];
    exp_inst[0] = 32'h00; exp_inst[1] = 32'h11; exp_inst[2] = 32'h22; exp_inst[3] = 32'h33;
    exp_pc[0] = 32'h1000; exp_pc[1] = 32'h1004; exp_pc[2] = 32'h1008; exp_pc[3] = 32'h100C;
    bus.inst_ready_i = 1'b0;
    drive(1'b1, {32'h33, 32'h22, 32'h11, 32'h00}, 32'h1000, 2'd0);
    step();
    drive(1'b0, '0, '0, 2'd0);
    bus.inst_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.inst_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid k=%0d got=%b exp=1", k, bus.inst_valid_o); end
      checks++; if (bus.inst_o !== exp_inst[k]) begin failures++; $display("FAIL single_inst k=%0d got=%h exp=%h", k, bus.inst_o, exp_inst[k]); end
      checks++; if (bus.inst_pc_o !== exp_pc[k]) begin failures++; $display("FAIL single_pc k=%0d got=%h exp=%h", k, bus.inst_pc_o, exp_pc[k]); end
      step();
    end
    #1;
    checks++; if (bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL single_end_valid got=%b exp=0", bus.inst_valid_o); end
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL single_end_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_mid_line();
    bus.inst_ready_i = 1'b0;
    drive(1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 32'h2008, 2'd2);
    step();
    drive(1'b0, '0, '0, 2'd0);
    bus.inst_ready_i = 1'b1;
    #1;
    checks++; if (bus.inst_o !== 32'hA2) begin failures++; $display("FAIL mid_inst2 got=%h exp=000000a2", bus.inst_o); end
    checks++; if (bus.inst_pc_o !== 32'h2008) begin failures++; $display("FAIL mid_pc2 got=%h exp=00002008", bus.inst_pc_o); end
    step();
    #1;
    checks++; if (bus.inst_o !== 32'hA3) begin failures++; $display("FAIL mid_inst3 got=%h exp=000000a3", bus.inst_o); end
    checks++; if (bus.inst_pc_o !== 32'h200C) begin failures++; $display("FAIL mid_pc3 got=%h exp=0000200c", bus.inst_pc_o); end
    step();
    #1;
    checks++; if (bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL mid_end_valid got=%b exp=0", bus.inst_valid_o); end
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL mid_end_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] ei;
    logic [31:0] ep;
    bus.inst_ready_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, {32'h0300 + b*16 + 3, 32'h0300 + b*16 + 2, 32'h0300 + b*16 + 1, 32'h0300 + b*16},
            32'h4000 + b*16, 2'd0);
      step();
    end
    drive(1'b1, {4{32'hDEAD_BEEF}}, 32'h9000, 2'd0);
    #1;
    checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count_o); end
    checks++; if (bus.bundle_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", bus.bundle_ready_o); end
    step();
    step();
    checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL full_hold_count got=%0d exp=4", count_o); end
    drive(1'b0, '0, '0, 2'd0);
    bus.inst_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ei = 32'h0300 + (i / 4) * 16 + (i % 4);
      ep = 32'h4000 + i * 4;
      #1;
      checks++; if (bus.inst_o !== ei) begin failures++; $display("FAIL wrap_inst i=%0d got=%h exp=%h", i, bus.inst_o, ei); end
      checks++; if (bus.inst_pc_o !== ep) begin failures++; $display("FAIL wrap_pc i=%0d got=%h exp=%h", i, bus.inst_pc_o, ep); end
      step();
    end
    #1;
    checks++; if (bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL wrap_end_valid got=%b exp=0", bus.inst_valid_o); end
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL wrap_end_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ei;
    logic [31:0] ep;
    bus.inst_ready_i = 1'b0;
    drive(1'b1, {32'hB003, 32'hB002, 32'hB001, 32'hB000}, 32'h5000, 2'd0);
    step();
    bus.inst_ready_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3 && b < 2)
          drive(1'b1, {32'hB003 + (b+1)*16, 32'hB002 + (b+1)*16, 32'hB001 + (b+1)*16, 32'hB000 + (b+1)*16},
                32'h5000 + (b+1)*16, 2'd0);
        else
          drive(1'b0, '0, '0, 2'd0);
        ei = 32'hB000 + b*16 + k;
        ep = 32'h5000 + b*16 + k*4;
        #1;
        checks++; if (bus.inst_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_valid b=%0d k=%0d got=%b exp=1", b, k, bus.inst_valid_o); end
        checks++; if (bus.inst_o !== ei) begin failures++; $display("FAIL b2b_inst b=%0d k=%0d got=%h exp=%h", b, k, bus.inst_o, ei); end
        checks++; if (bus.inst_pc_o !== ep) begin failures++; $display("FAIL b2b_pc b=%0d k=%0d got=%h exp=%h", b, k, bus.inst_pc_o, ep); end
        checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL b2b_count b=%0d k=%0d got=%0d exp=1", b, k, count_o); end
        step();
      end
    end
    #1;
    checks++; if (bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", bus.inst_valid_o); end
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL b2b_end_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_flush();
    bus.inst_ready_i = 1'b0;
    drive(1'b1, {4{32'hF1F1_0000}}, 32'h7000, 2'd0);
    step();
    drive(1'b1, {4{32'hF2F2_0000}}, 32'h7010, 2'd0);
    step();
    #1;
    checks++; if (count_o !== 3'd2) begin failures++; $display("FAIL flush_pre_count got=%0d exp=2", count_o); end
    flush_i = 1'b1;
    bus.inst_ready_i = 1'b1;
    drive(1'b1, {4{32'hBAD0_BAD0}}, 32'h7020, 2'd0);
    step();
    flush_i = 1'b0;
    bus.inst_ready_i = 1'b0;
    drive(1'b0, '0, '0, 2'd0);
    #1;
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    checks++; if (bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.inst_valid_o); end
    checks++; if (bus.bundle_ready_o !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", bus.bundle_ready_o); end
    drive(1'b1, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 32'h7100, 2'd1);
    step();
    drive(1'b0, '0, '0, 2'd0);
    bus.inst_ready_i = 1'b1;
    #1;
    checks++; if (bus.inst_o !== 32'hE1) begin failures++; $display("FAIL flush_after_inst got=%h exp=000000e1", bus.inst_o); end
    checks++; if (bus.inst_pc_o !== 32'h7104) begin failures++; $display("FAIL flush_after_pc got=%h exp=00007104", bus.inst_pc_o); end
    checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL flush_after_count got=%0d exp=1", count_o); end
    step();
    step();
    step();
    #1;
    checks++; if (bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL flush_drain_valid got=%b exp=0", bus.inst_valid_o); end
  endtask

  task automatic test_bypass();
    bus.inst_ready_i = 1'b1;
    drive(1'b1, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 32'h6000, 2'd3);
    #1;
`ifdef FETCH_BUF_BYPASS_EN
    checks++; if (bus.inst_valid_o !== 1'b1) begin failures++; $display("FAIL byp_valid got=%b exp=1", bus.inst_valid_o); end
    checks++; if (bus.inst_o !== 32'hC3) begin failures++; $display("FAIL byp_inst got=%h exp=000000c3", bus.inst_o); end
    checks++; if (bus.inst_pc_o !== 32'h600C) begin failures++; $display("FAIL byp_pc got=%h exp=0000600c", bus.inst_pc_o); end
    step();
    drive(1'b0, '0, '0, 2'd0);
    #1;
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL byp_count got=%0d exp=0", count_o); end
    checks++; if (bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL byp_after_valid got=%b exp=0", bus.inst_valid_o); end
`else
    checks++; if (bus.inst_valid_o !== 1'b0) begin failures++; $display("FAIL nobyp_same_valid got=%b exp=0", bus.inst_valid_o); end
    step();
    drive(1'b0, '0, '0, 2'd0);
    #1;
    checks++; if (bus.inst_valid_o !== 1'b1) begin failures++; $display("FAIL nobyp_valid got=%b exp=1", bus.inst_valid_o); end
    checks++; if (bus.inst_o !== 32'hC3) begin failures++; $display("FAIL nobyp_inst got=%h exp=000000c3", bus.inst_o); end
    checks++; if (bus.inst_pc_o !== 32'h600C) begin failures++; $display("FAIL nobyp_pc got=%h exp=0000600c", bus.inst_pc_o); end
    checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL nobyp_count got=%0d exp=1", count_o); end
    step();
    #1;
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL nobyp_end_count got=%0d exp=0", count_o); end
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_mid_line();
    test_full_wrap();
    test_back_to_back();
    test_flush();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
